// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM receiver that aligns on frame markers and presents N lanes once per frame.
module tdm_demux #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in,
    input  logic         valid,
    input  logic         frame,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic         locked,
    output logic         sync_err
);
    logic [SW-1:0] r_slot;
    logic [N-1:0]  r_shadow;
    logic [N-1:0]  r_out;
    logic          r_out_valid;
    logic          r_locked;
    logic          r_sync_err;
    logic          w_slot_zero;
    logic          w_slot_last;
    assign w_slot_zero = r_slot == '0;
    assign w_slot_last = r_slot == SW'(N - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot      <= '0;
            r_shadow    <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            if (valid) begin
                if (frame) begin
                    // a marker before the last slot means the frame was short; its bits are dropped
                    r_shadow[0] <= in;
                    r_slot      <= SW'(1);
                    r_locked    <= 1'b1;
                    r_sync_err  <= r_locked && !w_slot_zero;
                end else if (r_locked) begin
                    if (w_slot_zero) begin
                        r_sync_err <= 1'b1;
                        r_locked   <= 1'b0;
                    end else if (w_slot_last) begin
                        r_out       <= {in, r_shadow[N-2:0]};
                        r_out_valid <= 1'b1;
                        r_slot      <= '0;
                    end else begin
                        r_shadow[r_slot] <= in;
                        r_slot           <= r_slot + SW'(1);
                    end
                end
            end
        end
    end
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign locked    = r_locked;
    assign sync_err  = r_sync_err;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: table-driven cycle checks plus an out_valid scoreboard for tdm_demux (N=4).
module tb_tdm_demux;
    typedef struct {
        logic       v;
        logic       f;
        logic       d;
        logic [3:0] eo;
        logic       eov;
        logic       elk;
        logic       eerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in;
    logic       valid;
    logic       frame;
    logic [3:0] out;
    logic       out_valid;
    logic       locked;
    logic       sync_err;

    int         tests = 0;
    int         fails = 0;
    vec_t       vecs[$];
    logic [3:0] sb[$];

    tdm_demux #(.N(4)) dut (
        .clk(clk), .reset(reset), .in(in), .valid(valid), .frame(frame),
        .out(out), .out_valid(out_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v, f, d, input logic [3:0] eo, input logic eov, elk, eerr);
        vecs.push_back('{v, f, d, eo, eov, elk, eerr});
    endfunction

    // Scoreboard: every out_valid pulse must deliver the next expected frame word.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out_valid", {28'd0, out}, 32'hx);
            end else begin
                chk("sb_out", {28'd0, out}, {28'd0, sb.pop_front()});
            end
        end
    end

    task automatic run(input int from, input int to);
        for (int i = from; i < to; i++) begin
            valid = vecs[i].v;
            frame = vecs[i].f;
            in    = vecs[i].d;
            if (vecs[i].eov) sb.push_back(vecs[i].eo);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out", i), {28'd0, out}, {28'd0, vecs[i].eo});
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].eov});
            chk($sformatf("v%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].elk});
            chk($sformatf("v%0d_sync_err", i), {31'd0, sync_err}, {31'd0, vecs[i].eerr});
        end
    endtask

    initial begin
        int split;
        // idle after reset
        repeat (5) add(0, 0, 0, 4'b0000, 0, 0, 0);
        // pre-lock garbage is ignored
        repeat (3) add(1, 0, 1, 4'b0000, 0, 0, 0);
        // clean frame 1,0,1,1
        add(1, 1, 1, 4'b0000, 0, 1, 0);
        add(1, 0, 0, 4'b0000, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 0);
        add(1, 0, 1, 4'b1101, 1, 1, 0);
        // back-to-back frames 0110 and 1001
        add(1, 1, 0, 4'b1101, 0, 1, 0);
        add(1, 0, 1, 4'b1101, 0, 1, 0);
        add(1, 0, 1, 4'b1101, 0, 1, 0);
        add(1, 0, 0, 4'b0110, 1, 1, 0);
        add(1, 1, 1, 4'b0110, 0, 1, 0);
        add(1, 0, 0, 4'b0110, 0, 1, 0);
        add(1, 0, 0, 4'b0110, 0, 1, 0);
        add(1, 0, 1, 4'b1001, 1, 1, 0);
        // frame 1,1,0,0 with a valid gap; frame during the gap must be ignored
        add(1, 1, 1, 4'b1001, 0, 1, 0);
        add(1, 0, 1, 4'b1001, 0, 1, 0);
        add(0, 0, 0, 4'b1001, 0, 1, 0);
        add(0, 1, 1, 4'b1001, 0, 1, 0);
        add(0, 0, 1, 4'b1001, 0, 1, 0);
        add(1, 0, 0, 4'b1001, 0, 1, 0);
        add(1, 0, 0, 4'b0011, 1, 1, 0);
        // reload 1101, then a short frame
        add(1, 1, 1, 4'b0011, 0, 1, 0);
        add(1, 0, 0, 4'b0011, 0, 1, 0);
        add(1, 0, 1, 4'b0011, 0, 1, 0);
        add(1, 0, 1, 4'b1101, 1, 1, 0);
        add(1, 1, 0, 4'b1101, 0, 1, 0);
        add(1, 0, 1, 4'b1101, 0, 1, 0);
        add(1, 0, 1, 4'b1101, 0, 1, 0);
        add(1, 1, 1, 4'b1101, 0, 1, 1);
        add(1, 0, 0, 4'b1101, 0, 1, 0);
        add(1, 0, 0, 4'b1101, 0, 1, 0);
        add(1, 0, 0, 4'b0001, 1, 1, 0);
        // long frame: missing marker at slot 0
        add(1, 0, 1, 4'b0001, 0, 0, 1);
        add(1, 0, 1, 4'b0001, 0, 0, 0);
        // partial new frame before the mid-frame reset
        add(1, 1, 0, 4'b0001, 0, 1, 0);
        add(1, 0, 1, 4'b0001, 0, 1, 0);
        split = vecs.size();
        // after reset: a fresh frame 1,1,1,0
        add(1, 1, 1, 4'b0000, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 0);
        add(1, 0, 0, 4'b0111, 1, 1, 0);
        add(0, 0, 0, 4'b0111, 0, 1, 0);

        reset = 1'b0;
        in    = 1'b0;
        valid = 1'b0;
        frame = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {28'd0, out}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
        reset = 1'b1;

        run(0, split);

        // asynchronous reset mid-frame: effect must appear before any clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out", {28'd0, out}, 32'd0);
        chk("async_rst_locked", {31'd0, locked}, 32'd0);
        chk("async_rst_sync_err", {31'd0, sync_err}, 32'd0);
        valid = 1'b1;
        frame = 1'b1;
        in    = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_locked", {31'd0, locked}, 32'd0);
        chk("rst_hold_out", {28'd0, out}, 32'd0);
        valid = 1'b0;
        frame = 1'b0;
        reset = 1'b1;

        run(split, vecs.size());

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division 1-to-N demultiplexer: the receive end of a serial TDM link whose transmit end is a rotating N:1 mux.
- Takes a 1-bit serial stream plus a frame-sync marker. Steers each valid bit into the lane for the current slot. Presents all N lanes in parallel, registered, once per complete frame.
- Used between a serialized lab datapath (switch/LED lanes) and parallel consumer logic.

Parameters:
- N, 4, number of lanes/slots per frame; legal range 2..16.
- SW, $clog2(N), width of the slot counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in  input  1  serial data bit.
- valid  input  1  in/frame are sampled only on cycles where valid=1.
- frame  input  1  marks the bit in this cycle as slot 0; meaningful only with valid=1.
- out  output  N  parallel lanes; out[k] is the bit received in slot k of the last complete frame.
- out_valid  output  1  one-cycle pulse; out was updated on the same edge.
- locked  output  1  1 = receiver is aligned to frame boundaries.
- sync_err  output  1  one-cycle pulse; a frame-alignment violation was detected.

Behaviour:
- Reset (reset=0, asynchronous): slot=0, shadow=0, out=0, out_valid=0, locked=0, sync_err=0. Held while reset=0. Release is synchronous to the next clk edge.
- Internal state:
  - slot: SW-bit counter.
  - shadow: N-bit partial-frame register.
- Defaults every cycle: out_valid<=0, sync_err<=0. All other registers hold unless a rule below applies.
- valid=0: nothing changes except the two pulses clear. frame is ignored.
- valid=1, frame=1 (start of frame):
  - Effect: shadow[0]<=in, slot<=1, locked<=1.
  - If locked=1 and slot!=0, the previous frame was short: sync_err<=1, partial frame discarded, out unchanged.
  - If locked=1 and slot==0: normal, no error.
- valid=1, frame=0, locked=0: bit discarded, no state change.
- valid=1, frame=0, locked=1, slot==0:
  - Slot 0 was expected to carry frame (long frame or missing marker).
  - sync_err<=1, locked<=0, bit discarded, out unchanged.
- valid=1, frame=0, locked=1, 0<slot<N-1: shadow[slot]<=in, slot<=slot+1.
- valid=1, frame=0, locked=1, slot==N-1 (frame complete):
  - out<={in, shadow[N-2:0]}, out_valid<=1, slot<=0.
  - shadow is not required to clear.
- Latency: out and out_valid change on the same edge that samples the slot N-1 bit, so they are visible one cycle after that bit is presented.
- Gaps: valid may drop for any number of cycles mid-frame. slot and shadow hold, and the frame resumes when valid returns.
- Back-to-back frames: frame=1 on the cycle after slot N-1 completes is the normal case and raises no error.
- out holds its value indefinitely between completed frames, including across sync errors and loss of lock.
- Reset mid-frame: partial frame lost, out returns to 0, locked=0.

Test Plan (N=4):
- Reset then idle: reset=0 for 2 cycles, then valid=0 for 5 cycles -> out=0000, out_valid=0, locked=0, sync_err=0 throughout.
- Pre-lock garbage then a clean frame:
  - Stimulus: valid=1, frame=0, in=1 for 3 cycles (ignored, locked stays 0). Then slots 0..3 = 1,0,1,1 with frame=1 on slot 0.
  - Response: after the slot-3 edge, out=4'b1101, out_valid high exactly 1 cycle, locked=1.
- Continuous frames: frames 0110 then 1001 (slot-0 bit first) sent back to back with valid=1 every cycle.
  - Response: out=4'b0110 then 4'b1001, out_valid pulses 4 cycles apart, sync_err never set.
- Valid gaps: a frame with slots 1,1,0,0 and valid=0 for 3 cycles between slots 1 and 2 -> out=4'b0011, one out_valid pulse, timed at the slot-3 sample.
- Short frame:
  - Stimulus: locked, out=4'b1101. Send frame=1 at slot 0, 2 more bits, then frame=1 again.
  - Response: sync_err pulses 1 cycle, out stays 1101, new frame proceeds from slot 1 and completes normally.
- Long frame then reset:
  - After a complete frame, send valid=1, frame=0 -> sync_err pulse, locked=0.
  - Then assert reset=0 mid-way through a new frame -> out=0000, locked=0 immediately, without waiting for a clock edge.
